// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types for the two-master memory arbiter.
//   ArbState : arbiter FSM encoding (idle / request to slave / await response)
//   Master   : identity of a requesting master, also used as the grant value
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } ArbState;

    typedef enum logic {
        M_IFU = 1'b0,
        M_LSU = 1'b1
    } Master;

    // The master that is not m; used by the round-robin choice.
    function automatic Master other_master(input Master m);
        return (m == M_IFU) ? M_LSU : M_IFU;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
//   Purely combinational grant selection between IFU and LSU. Keeps the
//   arbitration policy out of the arbiter FSM.
//   Build option: ARB_RR_EN defined   -> round-robin on contention, using
//                                        last_grant
//                 ARB_RR_EN undefined -> fixed priority, LSU wins
//   Ports:
//     ifu_valid  in   IFU is requesting
//     lsu_valid  in   LSU is requesting
//     last_grant in   master granted on the most recent accept
//     grant      out  chosen master (meaningful only when any = 1)
//     any        out  at least one master is requesting
// ---------------------------------------------------------------------------
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic  ifu_valid,
    input  logic  lsu_valid,
    input  Master last_grant,
    output Master grant,
    output logic  any
);

`ifndef ARB_RR_EN
    // Fixed priority ignores history; the sink keeps the port connected.
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;
`endif

    always_comb begin
        any   = ifu_valid | lsu_valid;
        grant = M_IFU;
`ifdef ARB_RR_EN
        if (ifu_valid && lsu_valid) begin
            grant = other_master(last_grant);
        end else if (lsu_valid) begin
            grant = M_LSU;
        end else begin
            grant = M_IFU;
        end
`else
        if (lsu_valid) begin
            grant = M_LSU;
        end else begin
            grant = M_IFU;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory slave port between instruction fetch (IFU, read only)
//   and load/store (LSU). One transaction in flight: the winning request is
//   latched in ARB_IDLE, presented to the slave in ARB_REQ, and the single
//   response is steered back to the owner in ARB_RSP.
//   Build option: ARB_RR_EN selects round-robin arbitration (see arb_pick);
//   default is fixed LSU priority.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     ifu_req_valid/ready, ifu_addr IFU read request handshake and address
//     ifu_rsp_valid, ifu_rdata      IFU response pulse and read data
//     lsu_req_valid/ready           LSU request handshake
//     lsu_addr/wen/wdata/wstrb      LSU request fields
//     lsu_rsp_valid, lsu_rdata      LSU response pulse (load data / store ack)
//     mem_req_valid/ready           slave request handshake
//     mem_addr/wen/wdata/wstrb      latched request fields to slave
//     mem_rsp_valid, mem_rdata      slave response
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    ArbState             r_state;
    ArbState             w_next_state;
    Master               r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;

    Master               w_grant;
    Master               w_last_grant;
    logic                w_any;
    logic                w_accept;

    arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (w_last_grant),
        .grant      (w_grant),
        .any        (w_any)
    );

    // A request is taken only from ARB_IDLE, and never while reset is held
    // so nothing is latched or acknowledged during reset.
    assign w_accept = !rst && (r_state == ARB_IDLE) && w_any;

`ifdef ARB_RR_EN
    // Reset to LSU so that the first contention goes to IFU.
    Master r_last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= M_LSU;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = M_LSU;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: if (w_any)         w_next_state = ARB_REQ;
            ARB_REQ:  if (mem_req_ready) w_next_state = ARB_RSP;
            ARB_RSP:  if (mem_rsp_valid) w_next_state = ARB_IDLE;
            default:                     w_next_state = ARB_IDLE;
        endcase
    end

    // Output logic. Handshake outputs are forced low while reset is held so
    // a response arriving during reset is never forwarded.
    always_comb begin
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        if (!rst) begin
            case (r_state)
                ARB_IDLE: begin
                    ifu_req_ready = w_any && (w_grant == M_IFU);
                    lsu_req_ready = w_any && (w_grant == M_LSU);
                end
                ARB_REQ: begin
                    mem_req_valid = 1'b1;
                end
                ARB_RSP: begin
                    ifu_rsp_valid = mem_rsp_valid && (r_owner == M_IFU);
                    lsu_rsp_valid = mem_rsp_valid && (r_owner == M_LSU);
                end
                default: begin
                    ifu_req_ready = 1'b0;
                end
            endcase
        end
    end

    // Request latch: fields stay stable from accept until the next accept,
    // so the slave sees constant values for the whole of ARB_REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= M_IFU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_owner <= w_grant;
            if (w_grant == M_LSU) begin
                r_addr  <= lsu_addr;
                r_wen   <= lsu_wen;
                r_wdata <= lsu_wdata;
                r_wstrb <= lsu_wstrb;
            end else begin
                // Fetch is always a plain read.
                r_addr  <= ifu_addr;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_wstrb <= '0;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wen   = r_wen;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

    // Read data is broadcast; only the valid pulse identifies the owner.
    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Inputs change just after the rising edge; outputs are read at the
    // falling edge, i.e. with the values the next rising edge will commit.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic zero_inputs();
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wstrb = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1;
        zero_inputs();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        tick(); tick();
        samp();
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_req_valid got=%0b exp=0", mem_req_valid); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        total++; if (mem_wstrb !== 4'h0) begin bad++; $display("FAIL rst_mem_wstrb got=%h exp=0", mem_wstrb); end
        total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL rst_mem_wen got=%0b exp=0", mem_wen); end
        tick();
        ifu_req_valid = 1; lsu_req_valid = 1; mem_rsp_valid = 1; mem_rdata = 32'h5555_aaaa;
        samp();
        total++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", {ifu_req_ready, lsu_req_ready}); end
        total++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin bad++; $display("FAIL rst_rsp got=%b exp=00", {ifu_rsp_valid, lsu_rsp_valid}); end
        tick();
        zero_inputs();
        rst = 0;
        samp();
        total++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b000) begin bad++; $display("FAIL post_rst_idle got=%b exp=000", {ifu_req_ready, lsu_req_ready, mem_req_valid}); end
    endtask

    task automatic test_ifu_read();
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
        samp();
        total++; if (ifu_req_ready !== 1'b1) begin bad++; $display("FAIL ifu_rd_ready got=%0b exp=1", ifu_req_ready); end
        total++; if (lsu_req_ready !== 1'b0) begin bad++; $display("FAIL ifu_rd_lsu_ready got=%0b exp=0", lsu_req_ready); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL ifu_rd_c0_mreq got=%0b exp=0", mem_req_valid); end
        tick();
        ifu_req_valid = 0; ifu_addr = 32'hffff_ffff;
        samp();
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL ifu_rd_c1_mreq got=%0b exp=1", mem_req_valid); end
        total++; if (mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL ifu_rd_addr got=%h exp=80000000", mem_addr); end
        total++; if ({mem_wen, mem_wstrb} !== 5'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL ifu_rd_fields got=%0b/%h/%h exp=0/0/0", mem_wen, mem_wstrb, mem_wdata); end
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_0413;
        samp();
        total++; if (ifu_rsp_valid !== 1'b1) begin bad++; $display("FAIL ifu_rd_rsp got=%0b exp=1", ifu_rsp_valid); end
        total++; if (ifu_rdata !== 32'h0000_0413) begin bad++; $display("FAIL ifu_rd_data got=%h exp=00000413", ifu_rdata); end
        total++; if (lsu_rsp_valid !== 1'b0) begin bad++; $display("FAIL ifu_rd_lsu_rsp got=%0b exp=0", lsu_rsp_valid); end
        tick();
        mem_rsp_valid = 0;
        samp();
        total++; if ({ifu_rsp_valid, mem_req_valid} !== 2'b00) begin bad++; $display("FAIL ifu_rd_after got=%b exp=00", {ifu_rsp_valid, mem_req_valid}); end
    endtask

    task automatic test_lsu_store_stall();
        do_reset();
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        samp();
        total++; if (lsu_req_ready !== 1'b1) begin bad++; $display("FAIL st_ready got=%0b exp=1", lsu_req_ready); end
        tick();
        lsu_req_valid = 0; lsu_addr = 32'h0bad_0bad; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'h1; lsu_wen = 0;
        for (int s = 0; s < 4; s++) begin
            if (s == 3) mem_req_ready = 1;
            samp();
            total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL st_mreq_%0d got=%0b exp=1", s, mem_req_valid); end
            total++; if (mem_addr !== 32'h8000_1000 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF || mem_wen !== 1'b1)
                begin bad++; $display("FAIL st_fields_%0d got=%h/%h/%h/%0b exp=80001000/deadbeef/f/1", s, mem_addr, mem_wdata, mem_wstrb, mem_wen); end
            total++; if (lsu_rsp_valid !== 1'b0) begin bad++; $display("FAIL st_early_rsp_%0d got=%0b exp=0", s, lsu_rsp_valid); end
            tick();
        end
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0;
        samp();
        total++; if ({lsu_rsp_valid, ifu_rsp_valid, mem_req_valid} !== 3'b100) begin bad++; $display("FAIL st_rsp got=%b exp=100", {lsu_rsp_valid, ifu_rsp_valid, mem_req_valid}); end
        tick();
        mem_rsp_valid = 0;
        samp();
        total++; if (lsu_rsp_valid !== 1'b0) begin bad++; $display("FAIL st_pulse got=%0b exp=0", lsu_rsp_valid); end
    endtask

    // Both masters request continuously; record who wins each accept.
    task automatic test_contention();
        int exp_w [4];
        int acc_cyc, prev_acc, w;
        bit found;
`ifdef ARB_RR_EN
        exp_w = '{0, 1, 0, 1};
`else
        exp_w = '{1, 1, 1, 1};
`endif
        prev_acc = 0;
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h0000_1100;
        lsu_req_valid = 1; lsu_addr = 32'h0000_2200; lsu_wen = 0; lsu_wdata = 32'h0; lsu_wstrb = 4'h0;
        mem_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            found = 0;
            for (int c = 0; c < 10; c++) begin
                samp();
                if (ifu_req_ready || lsu_req_ready) begin found = 1; break; end
                tick();
            end
            total++;
            if (!found) begin
                bad++; $display("FAIL cont_timeout_%0d got=no_ready exp=ready", i);
                break;
            end
            acc_cyc = cyc;
            w = lsu_req_ready ? 1 : 0;
            if ((ifu_req_ready && lsu_req_ready) || w != exp_w[i]) begin
                bad++; $display("FAIL cont_grant_%0d got=ifu%0b_lsu%0b exp=%s", i, ifu_req_ready, lsu_req_ready, exp_w[i] ? "lsu" : "ifu");
            end
            if (i > 0) begin
                total++; if (acc_cyc - prev_acc != 3) begin bad++; $display("FAIL cont_gap_%0d got=%0d exp=3", i, acc_cyc - prev_acc); end
            end
            prev_acc = acc_cyc;
            tick();
            samp();
            total++; if (mem_req_valid !== 1'b1 || mem_addr !== (w ? 32'h0000_2200 : 32'h0000_1100))
                begin bad++; $display("FAIL cont_mem_%0d got=%0b/%h exp=1/%h", i, mem_req_valid, mem_addr, w ? 32'h0000_2200 : 32'h0000_1100); end
            tick();
            mem_rsp_valid = 1; mem_rdata = $urandom;
            samp();
            total++; if ({ifu_rsp_valid, lsu_rsp_valid} !== (w ? 2'b01 : 2'b10))
                begin bad++; $display("FAIL cont_rsp_%0d got=%b exp=%b", i, {ifu_rsp_valid, lsu_rsp_valid}, w ? 2'b01 : 2'b10); end
            tick();
            mem_rsp_valid = 0;
        end
        lsu_req_valid = 0;
        samp();
        total++; if (ifu_req_ready !== 1'b1) begin bad++; $display("FAIL cont_ifu_after got=%0b exp=1", ifu_req_ready); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h1234_5670; mem_req_ready = 1;
        samp();
        tick();
        ifu_req_valid = 0;
        samp();
        tick();
        mem_req_ready = 0; rst = 1; mem_rsp_valid = 1; mem_rdata = 32'hcafe_f00d;
        samp();
        total++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin bad++; $display("FAIL rmid_rsp_in_rst got=%b exp=00", {ifu_rsp_valid, lsu_rsp_valid}); end
        tick();
        rst = 0;
        samp();
        total++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin bad++; $display("FAIL rmid_late_rsp got=%b exp=00", {ifu_rsp_valid, lsu_rsp_valid}); end
        total++; if ({mem_req_valid, ifu_req_ready, lsu_req_ready} !== 3'b000) begin bad++; $display("FAIL rmid_ctrl got=%b exp=000", {mem_req_valid, ifu_req_ready, lsu_req_ready}); end
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0 || mem_wen !== 1'b0)
            begin bad++; $display("FAIL rmid_fields got=%h/%h/%h/%0b exp=0/0/0/0", mem_addr, mem_wdata, mem_wstrb, mem_wen); end
        tick();
        mem_rsp_valid = 0;
        lsu_req_valid = 1; lsu_addr = 32'h0000_0040; lsu_wen = 0;
        samp();
        total++; if (lsu_req_ready !== 1'b1) begin bad++; $display("FAIL rmid_new_accept got=%0b exp=1", lsu_req_ready); end
        tick();
        lsu_req_valid = 0; mem_req_ready = 1;
        samp();
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1;
        samp();
        total++; if (lsu_rsp_valid !== 1'b1) begin bad++; $display("FAIL rmid_new_rsp got=%0b exp=1", lsu_rsp_valid); end
        tick();
        mem_rsp_valid = 0;
    endtask

    task automatic test_spurious();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            mem_rsp_valid = 1; mem_rdata = $urandom;
            samp();
            total++; if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 3'b000)
                begin bad++; $display("FAIL spur_%0d got=%b exp=000", k, {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}); end
            tick();
        end
        mem_rsp_valid = 0;
        ifu_req_valid = 1; ifu_addr = 32'h0000_0800;
        samp();
        total++; if (ifu_req_ready !== 1'b1) begin bad++; $display("FAIL spur_idle got=%0b exp=1", ifu_req_ready); end
        tick();
        ifu_req_valid = 0;
    endtask

    // Transaction-level scoreboard: at most one outstanding transaction, the
    // winner follows the arbitration policy, the slave sees exactly the
    // winner's fields, and exactly one response returns to the winner.
    task automatic test_random();
        bit busy, hs, owner, last, win, acc, exp_mreq, rsp_phase;
        bit ipend, lpend;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_wstrb;
        logic        c_wen;
        int cnt, n_acc, n_rsp;
        busy = 0; hs = 0; owner = 0; last = 1; cnt = 0; n_acc = 0; n_rsp = 0;
        ipend = 0; lpend = 0;
        c_addr = 0; c_wdata = 0; c_wstrb = 0; c_wen = 0;
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            samp();
            exp_mreq  = busy && !hs;
            rsp_phase = busy && hs;
            acc = !busy && (ifu_req_valid || lsu_req_valid);
`ifdef ARB_RR_EN
            win = (ifu_req_valid && lsu_req_valid) ? !last : lsu_req_valid;
`else
            win = lsu_req_valid;
`endif
            total++; if (ifu_req_ready !== (acc && !win) || lsu_req_ready !== (acc && win))
                begin bad++; $display("FAIL rnd_ready t=%0d got=ifu%0b_lsu%0b exp=ifu%0b_lsu%0b", t, ifu_req_ready, lsu_req_ready, acc && !win, acc && win); end
            total++; if (mem_req_valid !== exp_mreq)
                begin bad++; $display("FAIL rnd_mreq t=%0d got=%0b exp=%0b", t, mem_req_valid, exp_mreq); end
            if (exp_mreq) begin
                total++; if (mem_addr !== c_addr || mem_wdata !== c_wdata || mem_wstrb !== c_wstrb || mem_wen !== c_wen)
                    begin bad++; $display("FAIL rnd_fields t=%0d got=%h/%h/%h/%0b exp=%h/%h/%h/%0b", t, mem_addr, mem_wdata, mem_wstrb, mem_wen, c_addr, c_wdata, c_wstrb, c_wen); end
            end
            total++; if (ifu_rsp_valid !== (rsp_phase && mem_rsp_valid && !owner) || lsu_rsp_valid !== (rsp_phase && mem_rsp_valid && owner))
                begin bad++; $display("FAIL rnd_rsp t=%0d got=ifu%0b_lsu%0b exp=ifu%0b_lsu%0b", t, ifu_rsp_valid, lsu_rsp_valid, rsp_phase && mem_rsp_valid && !owner, rsp_phase && mem_rsp_valid && owner); end
            if (mem_rsp_valid) begin
                total++; if (ifu_rdata !== mem_rdata || lsu_rdata !== mem_rdata)
                    begin bad++; $display("FAIL rnd_rdata t=%0d got=%h/%h exp=%h", t, ifu_rdata, lsu_rdata, mem_rdata); end
            end
            if (rsp_phase && mem_rsp_valid) begin busy = 0; hs = 0; n_rsp++; end
            if (exp_mreq && mem_req_ready) begin hs = 1; cnt = $urandom_range(0, 3); end
            if (acc) begin
                busy = 1; hs = 0; owner = win; last = win; n_acc++;
                if (win) begin
                    c_addr = lsu_addr; c_wdata = lsu_wdata; c_wstrb = lsu_wstrb; c_wen = lsu_wen; lpend = 0;
                end else begin
                    c_addr = ifu_addr; c_wdata = 0; c_wstrb = 0; c_wen = 0; ipend = 0;
                end
            end
            tick();
            if (!ipend && $urandom_range(0, 2) == 0) begin ipend = 1; ifu_addr = $urandom; end
            if (!lpend && $urandom_range(0, 2) == 0) begin
                lpend = 1; lsu_addr = $urandom; lsu_wen = 1'($urandom_range(0, 1));
                lsu_wdata = $urandom; lsu_wstrb = 4'($urandom_range(0, 15));
            end
            ifu_req_valid = ipend;
            lsu_req_valid = lpend;
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            if (busy && hs) begin
                if (cnt == 0) mem_rsp_valid = 1;
                else begin mem_rsp_valid = 0; cnt--; end
            end else begin
                mem_rsp_valid = ($urandom_range(0, 7) == 0);
            end
        end
        total++; if (n_acc < 50 || n_acc - n_rsp > 1)
            begin bad++; $display("FAIL rnd_progress got=acc%0d_rsp%0d exp=acc>=50_balanced", n_acc, n_rsp); end
        zero_inputs();
    endtask

    initial begin
        rst = 1;
        zero_inputs();
        test_reset();
        test_ifu_read();
        test_lsu_store_stall();
        test_contention();
        test_rst_mid();
        test_spurious();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter sharing a single memory port between instruction fetch (IFU) and load/store (LSU). Sits between the fetch and execute/memory stages and the memory slave, one transaction in flight at a time. Latches the winning request, drives it to the slave, and routes the single response back to the owner.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; wstrb width is DATA_W/8
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_rsp_valid  out  1  IFU read data valid, one-cycle pulse
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wstrb  in  DATA_W/8  store byte strobes
- lsu_rsp_valid  out  1  LSU response (load data or store ack), one-cycle pulse
- lsu_rdata  out  DATA_W  LSU load data
- mem_req_valid  out  1  request to slave
- mem_req_ready  in  1  slave accepts request
- mem_addr, mem_wen, mem_wdata, mem_wstrb  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_rsp_valid  in  1  slave response valid
- mem_rdata  in  DATA_W  slave response data

## Operation
- FSM states: ARB_IDLE, ARB_REQ, ARB_RSP; owner register (M_IFU/M_LSU).
- ARB_IDLE: if any req_valid, pick winner, assert winner's req_ready (combinational, this cycle only), latch addr/wen/wdata/wstrb (IFU: wen=0, wstrb=0, wdata=0), set owner, go ARB_REQ. Loser's req_ready = 0.
- ARB_REQ: mem_req_valid = 1 with latched fields, held stable; on mem_req_ready go ARB_RSP.
- ARB_RSP: on mem_rsp_valid, pulse owner's rsp_valid for that cycle, go ARB_IDLE.
- ifu_rdata = lsu_rdata = mem_rdata (unregistered); only rsp_valid is gated by owner.
- Fixed priority (default): LSU beats IFU on simultaneous requests.
- mem_rsp_valid in ARB_IDLE or ARB_REQ: ignored, never forwarded.
- Masters must hold req_valid and fields until req_ready; masters always accept responses (no rsp_ready).

## Timing
- Reset: state ARB_IDLE, owner M_IFU, all *_valid/*_ready outputs 0, mem_addr/mem_wdata/mem_wstrb/mem_wen 0.
- Min latency with zero-wait slave: accept cycle N, mem handshake N+1, rsp_valid N+2; next accept N+3.
- Slave stalls extend ARB_REQ/ARB_RSP indefinitely; no timeout.
- rst mid-transaction: back to ARB_IDLE next edge, transaction dropped, no rsp_valid emitted; later slave response ignored.
- Request arriving in ARB_REQ/ARB_RSP waits; evaluated in next ARB_IDLE.

## Configuration
- ARB_RR_EN defined: round-robin. last_grant register (reset M_LSU, so first contention goes to IFU); on simultaneous requests grant the master not last granted; updated on every accept. Lone requester always wins.
- ARB_RR_EN undefined: fixed LSU priority, no last_grant register.

## Structure
- Shared package (common.vh): typedef enum ArbState {ARB_IDLE, ARB_REQ, ARB_RSP}; typedef enum Master {M_IFU=0, M_LSU=1}.
- One sub-module: arb_pick (ifu_valid, lsu_valid, last_grant → grant, any); holds the priority/RR choice so the FSM stays policy-free.

## Test plan
- IFU read 0x8000_0000, zero-wait slave returns 0x0000_0413 → ifu_req_ready cycle 0, mem_req_valid cycle 1, ifu_rsp_valid=1, ifu_rdata=0x0000_0413 cycle 2, lsu_rsp_valid stays 0.
- LSU store addr 0x8000_1000, wdata 0xDEADBEEF, wstrb 0xF, slave ready after 3 stalls → mem fields stable throughout ARB_REQ, lsu_rsp_valid single pulse.
- IFU and LSU valid same cycle, fixed priority → LSU served first, IFU accepted in the cycle after LSU rsp (ARB_IDLE).
- Same with ARB_RR_EN, both held valid for 4 transactions → grant order IFU, LSU, IFU, LSU.
- rst asserted in ARB_RSP, slave then returns mem_rsp_valid → no rsp_valid to either master, state ARB_IDLE, outputs at reset values.
- Spurious mem_rsp_valid=1 in ARB_IDLE with no requests → no rsp_valid pulse, state unchanged.
